// File: rtl/axi_slv_pkg.sv
// axi_slv_pkg: shared burst/response encodings, FSM state types and the
// burst next-address helper used by axi_mem_slave.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    logic ok_s;
    case (len)
      8'd1, 8'd3, 8'd7, 8'd15: ok_s = 1'b1;
      default:                 ok_s = 1'b0;
    endcase
    return ok_s;
  endfunction

  // A burst errors out when its type is reserved, or WRAP is disabled or
  // used with an illegal length.
  function automatic logic burst_is_err(input burst_t burst, input logic [7:0] len,
                                        input logic wrap_en);
    logic err_s;
    case (burst)
      BURST_FIXED, BURST_INCR: err_s = 1'b0;
      BURST_WRAP:              err_s = ~wrap_en | ~wrap_len_ok(len);
      default:                 err_s = 1'b1;
    endcase
    return err_s;
  endfunction

  // Word index of the following beat. INCR wraps at the end of memory;
  // WRAP stays inside the aligned (len+1)-word block.
  function automatic logic [31:0] next_index(input logic [31:0] idx, input logic [7:0] len,
                                             input burst_t burst, input logic [31:0] depth);
    logic [31:0] inc_s;
    logic [31:0] mask_s;
    logic [31:0] nxt_s;
    inc_s  = idx + 32'd1;
    mask_s = {24'd0, len};
    case (burst)
      BURST_INCR: nxt_s = (inc_s == depth) ? 32'd0 : inc_s;
      BURST_WRAP: nxt_s = (idx & ~mask_s) | (inc_s & mask_s);
      default:    nxt_s = idx;
    endcase
    return nxt_s;
  endfunction

endpackage

// File: rtl/axi_slv_mem.sv
// axi_slv_mem: byte-enabled storage with one write port and one registered
// read port. Contents are never reset; only the read register is.
module axi_slv_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Byte-enabled write; storage has no reset so it survives rst.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read; a read in the same cycle as a write sees the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 memory slave with independent write and read FSMs.
// Optional feature: define AXI_SLV_WRAP_EN to support WRAP bursts; without
// it burst type 2 is treated as reserved and answered with SLVERR.
module axi_mem_slave
  import axi_slv_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int NB    = DATA_W / 8;
  localparam int SHIFT = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef AXI_SLV_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  // First word index of a burst: byte address to word, modulo memory size.
  function automatic logic [IDX_W-1:0] start_index(input logic [ADDR_W-1:0] addr);
    logic [31:0] w_s;
    w_s = 32'(addr >> SHIFT) % 32'(DEPTH);
    return IDX_W'(w_s);
  endfunction

  // ---------------- write path ----------------
  wstate_t          w_state_r, w_next_s;
  logic [ID_W-1:0]  w_id_r;
  logic [IDX_W-1:0] w_idx_r;
  logic [7:0]       w_len_r, w_cnt_r;
  burst_t           w_burst_r;
  logic             w_err_r, w_last_err_r;
  logic             awready_r, wready_r, bvalid_r;
  logic             awready_d_s, wready_d_s, bvalid_d_s;
  logic [ID_W-1:0]  bid_r;
  logic [1:0]       bresp_r;
  logic             aw_hs_s, w_hs_s, b_hs_s, w_final_s, wlast_bad_s;

  assign aw_hs_s     = awvalid & awready_r;
  assign w_hs_s      = wvalid & wready_r;
  assign b_hs_s      = bvalid_r & bready;
  assign w_final_s   = (w_cnt_r == w_len_r);
  assign wlast_bad_s = wlast ^ w_final_s;

  // Write FSM state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_next_s;
      awready_r <= awready_d_s;
      wready_r  <= wready_d_s;
      bvalid_r  <= bvalid_d_s;
    end
  end

  // Write FSM next-state decode.
  always_comb begin
    w_next_s = w_state_r;
    case (w_state_r)
      W_IDLE: if (aw_hs_s) w_next_s = W_DATA; else w_next_s = W_IDLE;
      W_DATA: if (w_hs_s && w_final_s) w_next_s = W_RESP; else w_next_s = W_DATA;
      W_RESP: if (b_hs_s) w_next_s = W_IDLE; else w_next_s = W_RESP;
      default: w_next_s = W_IDLE;
    endcase
  end

  // Write handshakes are decoded from the upcoming state so they leave flops.
  always_comb begin
    awready_d_s = (w_next_s == W_IDLE);
    wready_d_s  = (w_next_s == W_DATA);
    bvalid_d_s  = (w_next_s == W_RESP);
  end

  // Write burst bookkeeping: address/count stepping and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_id_r       <= {ID_W{1'b0}};
      w_idx_r      <= {IDX_W{1'b0}};
      w_len_r      <= 8'd0;
      w_cnt_r      <= 8'd0;
      w_burst_r    <= BURST_FIXED;
      w_err_r      <= 1'b0;
      w_last_err_r <= 1'b0;
      bid_r        <= {ID_W{1'b0}};
      bresp_r      <= 2'd0;
    end else if (aw_hs_s) begin
      w_id_r       <= awid;
      w_idx_r      <= start_index(awaddr);
      w_len_r      <= awlen;
      w_cnt_r      <= 8'd0;
      w_burst_r    <= burst_t'(awburst);
      w_err_r      <= burst_is_err(burst_t'(awburst), awlen, WRAP_EN);
      w_last_err_r <= 1'b0;
    end else if (w_hs_s) begin
      w_last_err_r <= w_last_err_r | wlast_bad_s;
      if (w_final_s) begin
        bid_r   <= w_id_r;
        bresp_r <= (w_err_r | w_last_err_r | wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        w_cnt_r <= w_cnt_r + 8'd1;
        w_idx_r <= IDX_W'(next_index(32'(w_idx_r), w_len_r, w_burst_r, 32'(DEPTH)));
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t          r_state_r, r_next_s;
  logic [IDX_W-1:0] r_idx_r, r_idx_nxt_s;
  logic [7:0]       r_len_r, r_cnt_r;
  burst_t           r_burst_r;
  logic             arready_r, rvalid_r, arready_d_s, rvalid_d_s;
  logic [ID_W-1:0]  rid_r;
  logic [1:0]       rresp_r;
  logic             rlast_r, r_zero_r;
  logic             ar_hs_s, r_hs_s, r_final_s;
  logic             mem_re_s;
  logic [IDX_W-1:0] mem_raddr_s;
  logic [DATA_W-1:0] mem_rdata_s;

  assign ar_hs_s     = arvalid & arready_r;
  assign r_hs_s      = rvalid_r & rready;
  assign r_final_s   = (r_cnt_r == r_len_r);
  assign r_idx_nxt_s = IDX_W'(next_index(32'(r_idx_r), r_len_r, r_burst_r, 32'(DEPTH)));

  // Read FSM state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
    end else begin
      r_state_r <= r_next_s;
      arready_r <= arready_d_s;
      rvalid_r  <= rvalid_d_s;
    end
  end

  // Read FSM next-state decode.
  always_comb begin
    r_next_s = r_state_r;
    case (r_state_r)
      R_IDLE: if (ar_hs_s) r_next_s = R_DATA; else r_next_s = R_IDLE;
      R_DATA: if (r_hs_s && r_final_s) r_next_s = R_IDLE; else r_next_s = R_DATA;
      default: r_next_s = R_IDLE;
    endcase
  end

  // Read handshakes decoded from the upcoming state.
  always_comb begin
    arready_d_s = (r_next_s == R_IDLE);
    rvalid_d_s  = (r_next_s == R_DATA);
  end

  // RAM read issue: first word on AR accept, next word only when the current
  // beat is taken, so rdata holds during back-pressure.
  always_comb begin
    if (ar_hs_s) begin
      mem_re_s    = 1'b1;
      mem_raddr_s = start_index(araddr);
    end else if (r_hs_s && !r_final_s) begin
      mem_re_s    = 1'b1;
      mem_raddr_s = r_idx_nxt_s;
    end else begin
      mem_re_s    = 1'b0;
      mem_raddr_s = r_idx_r;
    end
  end

  // Read burst bookkeeping: beat counting, rlast, echoed ID and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx_r   <= {IDX_W{1'b0}};
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
      r_burst_r <= BURST_FIXED;
      rid_r     <= {ID_W{1'b0}};
      rresp_r   <= 2'd0;
      rlast_r   <= 1'b0;
      r_zero_r  <= 1'b0;
    end else if (ar_hs_s) begin
      r_idx_r   <= start_index(araddr);
      r_len_r   <= arlen;
      r_cnt_r   <= 8'd0;
      r_burst_r <= burst_t'(arburst);
      rid_r     <= arid;
      rresp_r   <= burst_is_err(burst_t'(arburst), arlen, WRAP_EN) ? RESP_SLVERR : RESP_OKAY;
      rlast_r   <= (arlen == 8'd0);
      r_zero_r  <= burst_is_err(burst_t'(arburst), arlen, WRAP_EN);
    end else if (r_hs_s) begin
      if (r_final_s) begin
        rlast_r <= 1'b0;
      end else begin
        r_cnt_r <= r_cnt_r + 8'd1;
        r_idx_r <= r_idx_nxt_s;
        rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
      end
    end
  end

  axi_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_hs_s & ~w_err_r),
    .waddr (w_idx_r),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (mem_re_s),
    .raddr (mem_raddr_s),
    .rdata (mem_rdata_s)
  );

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bid     = bid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rid     = rid_r;
  assign rresp   = rresp_r;
  assign rlast   = rlast_r;
  assign rdata   = r_zero_r ? {DATA_W{1'b0}} : mem_rdata_s;

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized scoreboard bench for axi_mem_slave. Expected
// responses come from a word-array reference model and are queued when the
// stimulus is issued; a negedge monitor pops and compares them.
module tb_axi_mem_slave;

  localparam int ID_W = 4, ADDR_W = 12, DATA_W = 32, DEPTH = 1024;
  localparam int TMO = 400;

  logic clk, rst;
  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;

  axi_mem_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; logic [31:0] data; logic last; } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  b_exp_t eb;
  r_exp_t er;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  int vectors = 0, miscompares = 0, b_count = 0, r_count = 0;
  bit rr_rand = 1'b1, rr_force = 1'b1;
  bit hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic hold_last;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no handshake within %0d cycles", name, TMO);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Reference model: a burst is in error for type 3, or WRAP when disabled or of bad length.
  function automatic bit is_err(input int b, input int len);
    if (b == 3) return 1'b1;
    if (b == 2) begin
`ifdef AXI_SLV_WRAP_EN
      return !(len == 1 || len == 3 || len == 7 || len == 15);
`else
      return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  // Reference model: word touched by beat i of a burst.
  function automatic int beat_word(input int start, input int len, input int b, input int i);
    int n, base;
    case (b)
      0: return start;
      1: return (start + i) % DEPTH;
      2: begin
        n = len + 1;
        base = (start / n) * n;
        return base + ((start % n) + i) % n;
      end
      default: return start;
    endcase
  endfunction

  // Random response back-pressure (rready can be scripted instead).
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bready = ($urandom_range(0, 3) != 0);
      rready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_force;
    end
  end

  // Monitor: every B/R handshake pops one expectation; stalled R beats must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pending = 1'b0;
      end else begin
        if (bvalid && bready) begin
          if (exp_b.size() == 0) begin
            check("b_unexpected", 64'(1), 64'(0));
          end else begin
            eb = exp_b.pop_front();
            check("bid", 64'(bid), 64'(eb.id));
            check("bresp", 64'(bresp), 64'(eb.resp));
          end
          b_count++;
        end
        if (rvalid) begin
          if (hold_pending) begin
            check("r_hold_data", 64'(rdata), 64'(hold_data));
            check("r_hold_last", 64'(rlast), 64'(hold_last));
          end
          if (rready) begin
            if (exp_r.size() == 0) begin
              check("r_unexpected", 64'(1), 64'(0));
            end else begin
              er = exp_r.pop_front();
              check("rid", 64'(rid), 64'(er.id));
              check("rresp", 64'(rresp), 64'(er.resp));
              check("rdata", 64'(rdata), 64'(er.data));
              check("rlast", 64'(rlast), 64'(er.last));
            end
            r_count++;
            hold_pending = 1'b0;
          end else begin
            hold_pending = 1'b1;
            hold_data = rdata;
            hold_last = rlast;
          end
        end else begin
          hold_pending = 1'b0;
        end
      end
    end
  end

  // Write burst using wd/ws; bad_last puts wlast on beat 0 instead of the final beat.
  task automatic do_write(input logic [3:0] id, input int sw, input int len, input int b,
                          input bit bad_last);
    bit err;
    int target, k, w;
    err = is_err(b, len);
    eb.id = id;
    eb.resp = (err || bad_last) ? 2'd2 : 2'd0;
    exp_b.push_back(eb);
    if (!err) begin
      for (int i = 0; i <= len; i++) begin
        w = beat_word(sw, len, b, i);
        for (int j = 0; j < 4; j++) begin
          if (ws[i][j]) mem_m[w][j*8 +: 8] = wd[i][j*8 +: 8];
        end
      end
    end
    target = b_count + 1;
    @(posedge clk);
    #1;
    awid = id; awaddr = ADDR_W'(sw * 4); awlen = 8'(len); awburst = 2'(b); awvalid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (awready) break;
      k++;
      if (k > TMO) timeout_fail("aw_handshake");
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, 1)) begin
        wvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast = bad_last ? (i == 0) : (i == len);
      k = 0;
      forever begin
        @(negedge clk);
        if (wready) break;
        k++;
        if (k > TMO) timeout_fail("w_handshake");
      end
      @(posedge clk);
      #1;
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    check("b_latency", 64'(bvalid), 64'(1));
    k = 0;
    while (b_count < target) begin
      @(negedge clk);
      k++;
      if (k > TMO) timeout_fail("b_response");
    end
  endtask

  task automatic do_read(input logic [3:0] id, input int sw, input int len, input int b);
    bit err;
    int target, k;
    err = is_err(b, len);
    for (int i = 0; i <= len; i++) begin
      er.id = id;
      er.resp = err ? 2'd2 : 2'd0;
      er.data = err ? 32'd0 : mem_m[beat_word(sw, len, b, i)];
      er.last = (i == len);
      exp_r.push_back(er);
    end
    target = r_count + len + 1;
    @(posedge clk);
    #1;
    arid = id; araddr = ADDR_W'(sw * 4); arlen = 8'(len); arburst = 2'(b); arvalid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (arready) break;
      k++;
      if (k > TMO) timeout_fail("ar_handshake");
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    check("r_latency", 64'(rvalid), 64'(1));
    k = 0;
    while (r_count < target) begin
      @(negedge clk);
      k++;
      if (k > TMO) timeout_fail("r_beats");
    end
  endtask

  initial begin
    rst = 1'b1;
    awid = 4'd0; awaddr = 12'd0; awlen = 8'd0; awburst = 2'd0; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0;
    arid = 4'd0; araddr = 12'd0; arlen = 8'd0; arburst = 2'd0; arvalid = 1'b0;

    // Reset values and ready rise after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 64'(awready), 64'(0));
    check("rst_arready", 64'(arready), 64'(0));
    check("rst_wready", 64'(wready), 64'(0));
    check("rst_bvalid", 64'(bvalid), 64'(0));
    check("rst_rvalid", 64'(rvalid), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_outs", 64'({bid, bresp, rid, rresp, rlast}), 64'(0));
    rst = 1'b0;
    check("rel_awready_early", 64'(awready), 64'(0));
    @(posedge clk);
    #1;
    check("rel_awready", 64'(awready), 64'(1));
    check("rel_arready", 64'(arready), 64'(1));

    // Fill words 0..127 so every later read has defined data.
    for (int i = 0; i < 128; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'd1, 0, 127, 1, 1'b0);

    // INCR write at 0x010 of A0..A3, then read back.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(4'd3, 4, 3, 1, 1'b0);
    do_read(4'd3, 4, 3, 1);

    // WRAP read from 0x018, four beats.
    do_read(4'd5, 6, 3, 2);

    // Byte-lane merge.
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(4'd2, 5, 0, 0, 1'b0);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'h2;
    do_write(4'd2, 5, 0, 0, 1'b0);
    do_read(4'd2, 5, 0, 1);

    // Scripted rready stall mid-burst.
    fork
      do_read(4'd6, 16, 7, 1);
      begin
        rr_rand = 1'b0;
        rr_force = 1'b1;
        repeat (4) @(posedge clk);
        rr_force = 1'b0;
        repeat (3) @(posedge clk);
        rr_force = 1'b1;
      end
    join
    rr_rand = 1'b1;

    // wlast on the wrong beat: SLVERR, data still written.
    wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'd7, 30, 1, 1, 1'b1);
    do_read(4'd7, 30, 1, 1);

    // INCR wrapping past the top of memory.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'h5A5A0000 + 32'(i); ws[i] = 4'hF; end
    do_write(4'd8, 1022, 3, 1, 1'b0);
    do_read(4'd8, 1022, 3, 1);

    // FIXED write with mixed strobes, reserved-type write suppressed.
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'(1 << i); end
    do_write(4'd9, 40, 3, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hDEADBEEF; ws[i] = 4'hF; end
    do_write(4'd10, 41, 2, 3, 1'b0);
    do_read(4'd9, 40, 3, 1);
    do_read(4'd11, 41, 2, 3);

    // Randomized mix.
    for (int t = 0; t < 60; t++) begin
      int len, b, sw;
      logic [3:0] id;
      len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
      b = $urandom_range(0, 3);
      sw = $urandom_range(0, 127 - len);
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(id, sw, len, b, 1'b0);
      end else begin
        do_read(id, sw, len, b);
      end
    end

    // Reset during beat 2 of an 8-beat write to word 100.
    @(posedge clk);
    #1;
    awid = 4'd4; awaddr = ADDR_W'(100 * 4); awlen = 8'd7; awburst = 2'd1; awvalid = 1'b1;
    begin
      int k;
      k = 0;
      forever begin
        @(negedge clk);
        if (awready) break;
        k++;
        if (k > TMO) timeout_fail("aw_rst_burst");
      end
      @(posedge clk);
      #1;
      awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        wvalid = 1'b1; wdata = 32'h77000000 + 32'(i); wstrb = 4'hF; wlast = 1'b0;
        mem_m[100 + i] = 32'h77000000 + 32'(i);
        k = 0;
        forever begin
          @(negedge clk);
          if (wready) break;
          k++;
          if (k > TMO) timeout_fail("w_rst_burst");
        end
        @(posedge clk);
        #1;
      end
    end
    wvalid = 1'b1; wdata = 32'h77000002;
    @(negedge clk);
    rst = 1'b1;
    #1;
    wvalid = 1'b0;
    check("midrst_bvalid", 64'(bvalid), 64'(0));
    check("midrst_wready", 64'(wready), 64'(0));
    check("midrst_awready", 64'(awready), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_awready", 64'(awready), 64'(1));
    check("postrst_bvalid", 64'(bvalid), 64'(0));
    do_read(4'd12, 100, 7, 1);

    repeat (3) @(posedge clk);
    check("b_queue_empty", 64'(exp_b.size()), 64'(0));
    check("r_queue_empty", 64'(exp_r.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_W, default 12, byte-address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (power of 2, 8..128).
REQ-004 SHALL have parameter DEPTH, default 1024, memory size in DATA_W words.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have ports awid/arid  in  ID_W  write/read transaction ID.
REQ-008 SHALL have ports awaddr/araddr  in  ADDR_W  burst start byte address.
REQ-009 SHALL have ports awlen/arlen  in  8  beats minus one.
REQ-010 SHALL have ports awburst/arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
REQ-011 SHALL have ports awvalid,arvalid,wvalid,bready,rready  in  1  master handshakes.
REQ-012 SHALL have ports awready,arready,wready,bvalid,rvalid  out  1  slave handshakes.
REQ-013 SHALL have ports wdata  in  DATA_W and wstrb  in  DATA_W/8  write beat and byte enables.
REQ-014 SHALL have port wlast  in  1  last write beat.
REQ-015 SHALL have ports bid/rid  out  ID_W  echoed ID, bresp/rresp  out  2  response.
REQ-016 SHALL have ports rdata  out  DATA_W and rlast  out  1  read beat and last flag.

Function
REQ-017 Write and read paths SHALL be independent FSMs operating concurrently.
REQ-018 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE; AW accept moves to W_DATA next cycle.
REQ-019 In W_DATA wready SHALL be 1; each wvalid&wready beat writes bytes with wstrb set to the current word.
REQ-020 Beat counter reaching awlen SHALL move to W_RESP; bvalid asserts the cycle after the last beat and holds until bready, then W_IDLE.
REQ-021 wlast disagreeing with beat count SHALL give bresp=SLVERR (2); the burst still ends on count.
REQ-022 Read FSM SHALL use states R_IDLE, R_DATA; arready=1 only in R_IDLE; first rvalid one cycle after AR accept.
REQ-023 rdata/rid/rresp/rlast SHALL stay stable while rvalid&!rready; rlast=1 on beat arlen; R_IDLE after last handshake.
REQ-024 Word index SHALL be addr>>log2(DATA_W/8) modulo DEPTH; FIXED holds index, INCR adds 1 wrapping at DEPTH.
REQ-025 WRAP SHALL wrap within an aligned (len+1)-word block; len other than 1,3,7,15 gives SLVERR.
REQ-026 Burst type 3 SHALL give SLVERR: writes suppressed, reads return rdata=0, full beat count still honoured.
REQ-027 Same-cycle read and write of one word SHALL return the pre-write data.
REQ-028 Normal responses SHALL be OKAY (0).

Reset
REQ-029 rst SHALL asynchronously force W_IDLE/R_IDLE, all valid/ready outputs 0, bid/rid/bresp/rresp/rdata/rlast 0; readies rise first clock after release.
REQ-030 Reset mid-burst SHALL abandon the burst; memory contents SHALL NOT be reset.

Configuration
REQ-031 With AXI_SLV_WRAP_EN defined, WRAP bursts SHALL behave per REQ-025; without it, awburst/arburst=2 SHALL be treated as reserved per REQ-026.

Structure
REQ-032 Package axi_slv_pkg SHALL hold burst-type and response enums, FSM state typedefs and the next-address function.
REQ-033 Sub-module axi_slv_mem (byte-enabled 1W/1R registered-read RAM) SHALL hold storage.

Verification
REQ-034 INCR write awaddr=0x010, awlen=3, data 0xA0..0xA3, wstrb=0xF -> bresp=0 one cycle after beat 3; read-back gives 0xA0..0xA3, rlast on beat 3.
REQ-035 WRAP read araddr=0x018, arlen=3 -> words 6,7,4,5 returned; undefined macro -> rresp=2, rdata=0.
REQ-036 Write 0x11223344 then wstrb=0x2 wdata=0xFFFFFFFF -> read gives 0x1122FF44.
REQ-037 rready low for 3 cycles mid-burst -> rdata/rlast held stable, no beat lost; awlen=1 with wlast on beat 0 -> bresp=2.
REQ-038 rst pulse during beat 2 of 8-beat write -> bvalid=0, awready=1 after release, beats 0-1 persist in memory.
